mips_test_sequencer: RTL and testbench
======================================

// Module: mips_test_sequencer
// PURPOSE
//  Synthesizable, parametrised run controller and result checker for the single-cycle MIPS core.
//  - Releases the core's reset after a programmable hold.
//  - Compares the core's test-value output against a loaded table of expected values.
//  - Flags pass, fail or timeout within a cycle budget.
//  Sits beside the MIPS top: drives the core's reset_n and watches its test_valueO.
//  Replaces fixed-delay reset/stop sequencing, so checks run identically in simulation and on FPGA.
// PARAMETERS
//  VALUE_W      16   width of test_value and expected entries
//  DEPTH        16   expected-value table entries (power of 2); IDX_W = $clog2(DEPTH)
//  RESET_CYCLES 1    cycles cpu_reset_n is held low after start
//  MAX_CYCLES   45   run budget, in cycles after core reset release
//  CNT_W        16   width of cycle_count
// PORTS
//  clk          in   1        system clock, rising edge
//  reset_n      in   1        synchronous, active-low reset
//  exp_wr_en    in   1        write strobe into expected table
//  exp_wr_addr  in   IDX_W    table write address
//  exp_wr_data  in   VALUE_W  expected value
//  exp_count    in   IDX_W+1  number of valid entries (0..DEPTH), sampled at start
//  start        in   1        one-cycle pulse: begin a run
//  test_value   in   VALUE_W  core observation output
//  cpu_reset_n  out  1        reset to the MIPS core (active-low)
//  busy         out  1        high in HOLD and RUN
//  done         out  1        sticky; run finished
//  pass         out  1        sticky; valid when done
//  fail         out  1        sticky; valid when done (mismatch or timeout)
//  timeout      out  1        sticky; fail caused by budget exhaustion
//  fail_index   out  IDX_W    table index of the first mismatch
//  fail_value   out  VALUE_W  offending test_value
//  match_count  out  IDX_W+1  entries matched so far
//  cycle_count  out  CNT_W    cycles spent in RUN
// BEHAVIOUR
//  Reset (synchronous, reset_n low at posedge):
//  - All outputs are 0, including cpu_reset_n (core held in reset).
//  - FSM goes to IDLE. Table contents are not cleared.
//  - Reset asserted mid-run aborts the run at that edge.
//  FSM states: IDLE, HOLD, RUN, DONE.
//  IDLE
//  - cpu_reset_n=0.
//  - exp_wr_en writes the table; writes are ignored in every other state.
//  - On start: latch exp_count, clear status and counters, then go to HOLD.
//  HOLD
//  - cpu_reset_n stays 0 for exactly RESET_CYCLES cycles, then goes to RUN.
//  - cpu_reset_n rises on the edge that enters RUN.
//  RUN
//  - cycle_count increments every cycle, saturating.
//  - First RUN cycle: capture test_value as baseline prev; no compare on this cycle.
//  - Each later cycle with test_value != prev is an event: compare against exp[idx], then update prev.
//  - Match: idx and match_count increment. If match_count reaches the latched count, go to DONE with pass=1.
//  - Mismatch: go to DONE with fail=1, fail_index=idx, fail_value=test_value.
//  - cycle_count == MAX_CYCLES-1 with no terminal event: go to DONE with fail=1, timeout=1.
//  - Latched count == 0: no compares; reaching the budget gives pass=1, timeout=0 (smoke run).
//  - Final match and budget end on the same cycle: pass wins.
//  - Events after the count is reached are never evaluated.
//  DONE
//  - cpu_reset_n stays 1 (core keeps running); status and counters are frozen.
//  - start re-enters HOLD and clears status; table is reused.
//  - Outputs are registered, so status is visible the cycle after the deciding edge.
//  - start while busy is ignored.
//  - exp_count > DEPTH is clamped to DEPTH.
// STRUCTURE
//  Package mips_tb_pkg: state enum (IDLE, HOLD, RUN, DONE), default widths, VALUE_W and DEPTH defaults.
//  Sub-module mips_exp_mem:
//  - DEPTH x VALUE_W register file.
//  - One synchronous write port; one combinational read port indexed by idx.
//  - No reset on storage.
//  Top level holds the FSM, hold counter, cycle counter, change detector and status registers.
// TESTING
//  1. Load {0x0005,0x000A,0x000F}, count=3; core drives those values in order by cycle 20:
//     -> pass=1, match_count=3, timeout=0.
//  2. Same table; core drives 0x0005 then 0x000B:
//     -> fail=1, fail_index=1, fail_value=0x000B, match_count=1.
//  3. Same table; test_value stuck at baseline:
//     -> done after 45 RUN cycles, fail=1, timeout=1, cycle_count=45.
//  4. RESET_CYCLES=3:
//     -> cpu_reset_n low for exactly 3 cycles after start; busy high from the cycle after start.
//  5. reset_n low mid-RUN, then new start:
//     -> all status cleared, cpu_reset_n=0, table preserved, rerun passes.
//  6. count=0:
//     -> pass at budget end; exp_wr_en during RUN leaves the table unchanged.

Source files
------------

// File: rtl/mips_test_sequencer_pkg.sv
// Shared types and default sizing for the MIPS run controller / result checker.
package mips_tb_pkg;

  // Run controller states.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HOLD = 2'd1,
    ST_RUN  = 2'd2,
    ST_DONE = 2'd3
  } seq_state_e;

  // Default sizing of the sequencer and its expected-value table.
  localparam int DEF_VALUE_W      = 16;
  localparam int DEF_DEPTH        = 16;
  localparam int DEF_CNT_W        = 16;
  localparam int DEF_RESET_CYCLES = 1;
  localparam int DEF_MAX_CYCLES   = 45;

endpackage : mips_tb_pkg

// File: rtl/mips_test_sequencer_if.sv
// Control, table-load, core-observation and status bundle of the sequencer.
interface mips_test_sequencer_if #(
  parameter int VALUE_W = 16,
  parameter int DEPTH   = 16,
  parameter int CNT_W   = 16
);
  localparam int IDX_W = $clog2(DEPTH);

  logic               exp_wr_en;
  logic [IDX_W-1:0]   exp_wr_addr;
  logic [VALUE_W-1:0] exp_wr_data;
  logic [IDX_W:0]     exp_count;
  logic               start;
  logic [VALUE_W-1:0] test_value;

  logic               cpu_reset_n;
  logic               busy;
  logic               done;
  logic               pass;
  logic               fail;
  logic               timeout;
  logic [IDX_W-1:0]   fail_index;
  logic [VALUE_W-1:0] fail_value;
  logic [IDX_W:0]     match_count;
  logic [CNT_W-1:0]   cycle_count;

  // Host / core side: drives commands and observations, reads status.
  modport master (
    output exp_wr_en, exp_wr_addr, exp_wr_data, exp_count, start, test_value,
    input  cpu_reset_n, busy, done, pass, fail, timeout,
    input  fail_index, fail_value, match_count, cycle_count
  );

  // Sequencer side.
  modport slave (
    input  exp_wr_en, exp_wr_addr, exp_wr_data, exp_count, start, test_value,
    output cpu_reset_n, busy, done, pass, fail, timeout,
    output fail_index, fail_value, match_count, cycle_count
  );
endinterface : mips_test_sequencer_if

// File: rtl/mips_test_sequencer_exp_mem.sv
// Expected-value table: register file with one synchronous write port and a
// combinational read port. Storage is deliberately not reset so a table loaded
// once survives sequencer resets.
module mips_exp_mem #(
  parameter int VALUE_W = 16,
  parameter int DEPTH   = 16,
  parameter int IDX_W   = $clog2(DEPTH)
) (
  input  logic               clk,
  input  logic               wr_en_i,
  input  logic [IDX_W-1:0]   wr_addr_i,
  input  logic [VALUE_W-1:0] wr_data_i,
  input  logic [IDX_W-1:0]   rd_addr_i,
  output logic [VALUE_W-1:0] rd_data_o
);

  logic [VALUE_W-1:0] mem_q [DEPTH];

  // Write port: one entry per enabled cycle.
  always_ff @(posedge clk) begin
    if (wr_en_i) begin
      mem_q[wr_addr_i] <= wr_data_i;
    end
  end

  assign rd_data_o = mem_q[rd_addr_i];

endmodule : mips_exp_mem

// File: rtl/mips_test_sequencer.sv
// Run controller and result checker for the single-cycle MIPS core: holds the
// core in reset for a programmable time, then watches test_value for changes
// and checks each change against the expected table within a cycle budget.
module mips_test_sequencer
  import mips_tb_pkg::*;
#(
  parameter int VALUE_W      = DEF_VALUE_W,
  parameter int DEPTH        = DEF_DEPTH,
  parameter int RESET_CYCLES = DEF_RESET_CYCLES,
  parameter int MAX_CYCLES   = DEF_MAX_CYCLES,
  parameter int CNT_W        = DEF_CNT_W
) (
  input  logic                  clk,
  input  logic                  reset_n,
  mips_test_sequencer_if.slave  bus
);

  localparam int IDX_W  = $clog2(DEPTH);
  localparam int CI_W   = IDX_W + 1;
  localparam int HOLD_W = (RESET_CYCLES > 1) ? $clog2(RESET_CYCLES) : 1;

  seq_state_e         state_q;
  logic [HOLD_W-1:0]  hold_cnt_q;
  logic [CNT_W-1:0]   cycle_count_q;
  logic [VALUE_W-1:0] prev_q;
  logic               first_q;
  logic [IDX_W-1:0]   idx_q;
  logic [CI_W-1:0]    count_q;
  logic [CI_W-1:0]    match_count_q;
  logic               cpu_reset_n_q;
  logic               busy_q;
  logic               done_q;
  logic               pass_q;
  logic               fail_q;
  logic               timeout_q;
  logic [IDX_W-1:0]   fail_index_q;
  logic [VALUE_W-1:0] fail_value_q;

  logic [VALUE_W-1:0] exp_data;
  logic               mem_wr_en;
  logic [CI_W-1:0]    count_d;
  logic [CNT_W-1:0]   cycle_count_d;
  logic               change;
  logic               evaluate;
  logic               hit;
  logic               miss;
  logic               final_hit;
  logic               budget_end;

  // Table is writable only while idle so a running check can never be disturbed.
  assign mem_wr_en = bus.exp_wr_en && (state_q == ST_IDLE);

  mips_exp_mem #(
    .VALUE_W (VALUE_W),
    .DEPTH   (DEPTH),
    .IDX_W   (IDX_W)
  ) u_exp_mem (
    .clk       (clk),
    .wr_en_i   (mem_wr_en),
    .wr_addr_i (bus.exp_wr_addr),
    .wr_data_i (bus.exp_wr_data),
    .rd_addr_i (idx_q),
    .rd_data_o (exp_data)
  );

  // Change detection, compare and budget decisions for the current RUN cycle.
  always_comb begin
    count_d       = (bus.exp_count > CI_W'(DEPTH)) ? CI_W'(DEPTH) : bus.exp_count;
    cycle_count_d = (&cycle_count_q) ? cycle_count_q : cycle_count_q + 1'b1;
    change        = (bus.test_value != prev_q);
    // Once the latched count is reached no further event is evaluated.
    evaluate      = !first_q && change && (match_count_q < count_q);
    hit           = evaluate && (bus.test_value == exp_data);
    miss          = evaluate && !hit;
    final_hit     = hit && ((match_count_q + 1'b1) == count_q);
    budget_end    = (cycle_count_q == CNT_W'(MAX_CYCLES - 1));
  end

  // Sequencer FSM with all status outputs registered.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q       <= ST_IDLE;
      hold_cnt_q    <= '0;
      cycle_count_q <= '0;
      prev_q        <= '0;
      first_q       <= 1'b0;
      idx_q         <= '0;
      count_q       <= '0;
      match_count_q <= '0;
      cpu_reset_n_q <= 1'b0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      pass_q        <= 1'b0;
      fail_q        <= 1'b0;
      timeout_q     <= 1'b0;
      fail_index_q  <= '0;
      fail_value_q  <= '0;
    end else begin
      case (state_q)
        ST_IDLE, ST_DONE: begin
          if (bus.start) begin
            state_q       <= ST_HOLD;
            count_q       <= count_d;
            hold_cnt_q    <= '0;
            cycle_count_q <= '0;
            idx_q         <= '0;
            match_count_q <= '0;
            cpu_reset_n_q <= 1'b0;
            busy_q        <= 1'b1;
            done_q        <= 1'b0;
            pass_q        <= 1'b0;
            fail_q        <= 1'b0;
            timeout_q     <= 1'b0;
            fail_index_q  <= '0;
            fail_value_q  <= '0;
          end
        end
        ST_HOLD: begin
          if (hold_cnt_q == HOLD_W'(RESET_CYCLES - 1)) begin
            state_q       <= ST_RUN;
            cpu_reset_n_q <= 1'b1;
            first_q       <= 1'b1;
          end else begin
            hold_cnt_q <= hold_cnt_q + 1'b1;
          end
        end
        ST_RUN: begin
          cycle_count_q <= cycle_count_d;
          first_q       <= 1'b0;
          if (first_q || change) begin
            prev_q <= bus.test_value;
          end
          if (hit) begin
            idx_q         <= idx_q + 1'b1;
            match_count_q <= match_count_q + 1'b1;
          end
          // A final match on the budget's last cycle still counts as a pass.
          if (final_hit) begin
            state_q <= ST_DONE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            pass_q  <= 1'b1;
          end else if (miss) begin
            state_q      <= ST_DONE;
            busy_q       <= 1'b0;
            done_q       <= 1'b1;
            fail_q       <= 1'b1;
            fail_index_q <= idx_q;
            fail_value_q <= bus.test_value;
          end else if (budget_end) begin
            state_q <= ST_DONE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            if (count_q == '0) begin
              pass_q <= 1'b1;
            end else begin
              fail_q    <= 1'b1;
              timeout_q <= 1'b1;
            end
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign bus.cpu_reset_n = cpu_reset_n_q;
  assign bus.busy        = busy_q;
  assign bus.done        = done_q;
  assign bus.pass        = pass_q;
  assign bus.fail        = fail_q;
  assign bus.timeout     = timeout_q;
  assign bus.fail_index  = fail_index_q;
  assign bus.fail_value  = fail_value_q;
  assign bus.match_count = match_count_q;
  assign bus.cycle_count = cycle_count_q;

endmodule : mips_test_sequencer

// File: tb/tb_mips_test_sequencer.sv
// Directed bench for mips_test_sequencer: table of run vectors plus
// hand-written sequences for hold length, mid-run reset and smoke runs.
module tb_mips_test_sequencer;

  logic clk = 1'b0;
  logic reset_n;
  always #5 clk = ~clk;

  mips_test_sequencer_if #(.VALUE_W(16), .DEPTH(16), .CNT_W(16)) bus1 ();
  mips_test_sequencer_if #(.VALUE_W(16), .DEPTH(16), .CNT_W(16)) bus2 ();

  mips_test_sequencer #(
    .VALUE_W(16), .DEPTH(16), .RESET_CYCLES(1), .MAX_CYCLES(45), .CNT_W(16)
  ) dut1 (.clk(clk), .reset_n(reset_n), .bus(bus1));

  mips_test_sequencer #(
    .VALUE_W(16), .DEPTH(16), .RESET_CYCLES(3), .MAX_CYCLES(45), .CNT_W(16)
  ) dut2 (.clk(clk), .reset_n(reset_n), .bus(bus2));

  typedef struct {
    string            name;
    int               cnt;
    int               hold;   // RUN cycles each scripted value is held
    int               nv;     // number of scripted values (v[0] is the baseline)
    logic [4:0][15:0] v;
    logic             e_pass;
    logic             e_fail;
    logic             e_to;
    int               e_fidx;
    logic [15:0]      e_fval;
    int               e_match;
    int               e_cyc;
  } vec_t;

  int n_tests = 0;
  int n_fail  = 0;
  vec_t vecs [8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end else begin
      $display("ok   %s = 0x%0h", name, act);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic vec_t mk(input string name, input int cnt, input int hold, input int nv,
                              input logic [15:0] a, input logic [15:0] b, input logic [15:0] c,
                              input logic [15:0] d, input logic [15:0] e,
                              input logic p, input logic f, input logic t,
                              input int fidx, input logic [15:0] fval, input int m, input int cyc);
    vec_t r;
    r.name = name; r.cnt = cnt; r.hold = hold; r.nv = nv;
    r.v[0] = a; r.v[1] = b; r.v[2] = c; r.v[3] = d; r.v[4] = e;
    r.e_pass = p; r.e_fail = f; r.e_to = t;
    r.e_fidx = fidx; r.e_fval = fval; r.e_match = m; r.e_cyc = cyc;
    return r;
  endfunction

  task automatic write_exp(input logic [3:0] addr, input logic [15:0] data);
    bus1.exp_wr_en   = 1'b1;
    bus1.exp_wr_addr = addr;
    bus1.exp_wr_data = data;
    tick();
    bus1.exp_wr_en   = 1'b0;
  endtask

  // Start a run on dut1 and play the vector's script until done or the bound.
  task automatic run_vec(input vec_t t);
    int r = 0;
    int vi;
    bit fin = 0;
    logic [15:0] cyc_at_done;
    bus1.test_value = t.v[0];
    bus1.exp_count  = 5'(t.cnt);
    bus1.start      = 1'b1;
    tick();
    bus1.start      = 1'b0;
    check({t.name, ".busy_after_start"}, 32'(bus1.busy), 32'd1);
    check({t.name, ".core_held"}, 32'(bus1.cpu_reset_n), 32'd0);
    for (int k = 0; k < 200 && !fin; k++) begin
      if (bus1.busy && bus1.cpu_reset_n) begin
        vi = r / t.hold;
        if (vi > t.nv - 1) vi = t.nv - 1;
        bus1.test_value = t.v[vi];
        r++;
      end
      tick();
      if (bus1.done) fin = 1;
    end
    if (!fin) check({t.name, ".done_within_bound"}, 32'd0, 32'd1);
    check({t.name, ".pass"},        32'(bus1.pass),        32'(t.e_pass));
    check({t.name, ".fail"},        32'(bus1.fail),        32'(t.e_fail));
    check({t.name, ".timeout"},     32'(bus1.timeout),     32'(t.e_to));
    check({t.name, ".fail_index"},  32'(bus1.fail_index),  32'(t.e_fidx));
    check({t.name, ".fail_value"},  32'(bus1.fail_value),  32'(t.e_fval));
    check({t.name, ".match_count"}, 32'(bus1.match_count), 32'(t.e_match));
    check({t.name, ".cycle_count"}, 32'(bus1.cycle_count), 32'(t.e_cyc));
    check({t.name, ".busy_done"},   32'(bus1.busy),        32'd0);
    // Status must stay frozen in DONE while the core keeps running.
    cyc_at_done = bus1.cycle_count;
    bus1.test_value = 16'h1234;
    tick();
    tick();
    check({t.name, ".frozen_cycles"}, 32'(bus1.cycle_count), 32'(cyc_at_done));
    check({t.name, ".frozen_done"},   32'(bus1.done),        32'd1);
    check({t.name, ".core_running"},  32'(bus1.cpu_reset_n), 32'd1);
  endtask

  initial begin
    bit fin;
    reset_n = 1'b0;
    bus1.exp_wr_en = 0; bus1.exp_wr_addr = '0; bus1.exp_wr_data = '0;
    bus1.exp_count = '0; bus1.start = 0; bus1.test_value = '0;
    bus2.exp_wr_en = 0; bus2.exp_wr_addr = '0; bus2.exp_wr_data = '0;
    bus2.exp_count = '0; bus2.start = 0; bus2.test_value = '0;

    //                 name          cnt hold nv  values                                  p f t fidx fval   m cyc
    vecs[0] = mk("pass3",         3,  3, 4, 16'h0, 16'h5, 16'hA, 16'hF, 16'h0,   1, 0, 0, 0, 16'h0, 3, 10);
    vecs[1] = mk("mismatch2",     3,  3, 3, 16'h0, 16'h5, 16'hB, 16'h0, 16'h0,   0, 1, 0, 1, 16'hB, 1, 7);
    vecs[2] = mk("stuck",         3,  3, 1, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0,   0, 1, 1, 0, 16'h0, 0, 45);
    vecs[3] = mk("repeat_value",  3,  3, 5, 16'h0, 16'h5, 16'h5, 16'hA, 16'hF,   1, 0, 0, 0, 16'h0, 3, 13);
    vecs[4] = mk("last_cycle_hit",1, 44, 2, 16'h0, 16'h5, 16'h0, 16'h0, 16'h0,   1, 0, 0, 0, 16'h0, 1, 45);
    vecs[5] = mk("one_too_late",  1, 45, 2, 16'h0, 16'h5, 16'h0, 16'h0, 16'h0,   0, 1, 1, 0, 16'h0, 0, 45);
    vecs[6] = mk("extra_events",  2,  3, 4, 16'h0, 16'h5, 16'hA, 16'h1, 16'h0,   1, 0, 0, 0, 16'h0, 2, 7);
    vecs[7] = mk("mismatch_first",3,  3, 2, 16'h0, 16'h7, 16'h0, 16'h0, 16'h0,   0, 1, 0, 0, 16'h7, 0, 4);

    tick();
    tick();
    check("rst.cpu_reset_n", 32'(bus1.cpu_reset_n), 32'd0);
    check("rst.busy",        32'(bus1.busy),        32'd0);
    check("rst.done",        32'(bus1.done),        32'd0);
    check("rst.pass",        32'(bus1.pass),        32'd0);
    check("rst.fail",        32'(bus1.fail),        32'd0);
    check("rst.cycle_count", 32'(bus1.cycle_count), 32'd0);
    reset_n = 1'b1;
    tick();

    write_exp(4'd0, 16'h0005);
    write_exp(4'd1, 16'h000A);
    write_exp(4'd2, 16'h000F);

    foreach (vecs[i]) run_vec(vecs[i]);

    // Hold length of three cycles on the second instance.
    bus2.start = 1'b1;
    tick();
    bus2.start = 1'b0;
    check("hold3.busy_c1", 32'(bus2.busy),        32'd1);
    check("hold3.rst_c1",  32'(bus2.cpu_reset_n), 32'd0);
    tick();
    check("hold3.rst_c2",  32'(bus2.cpu_reset_n), 32'd0);
    tick();
    check("hold3.rst_c3",  32'(bus2.cpu_reset_n), 32'd0);
    tick();
    check("hold3.rst_rel", 32'(bus2.cpu_reset_n), 32'd1);

    // Mid-run start is ignored; mid-run reset aborts; the table survives.
    bus1.test_value = 16'h0;
    bus1.exp_count  = 5'd3;
    bus1.start      = 1'b1;
    tick();
    bus1.start      = 1'b0;
    for (int k = 0; k < 5; k++) tick();
    bus1.test_value = 16'h5;
    tick();
    bus1.start = 1'b1;
    tick();
    bus1.start = 1'b0;
    check("midrun.start_ignored_rst", 32'(bus1.cpu_reset_n), 32'd1);
    check("midrun.start_ignored_busy", 32'(bus1.busy),       32'd1);
    reset_n = 1'b0;
    tick();
    check("abort.cpu_reset_n", 32'(bus1.cpu_reset_n), 32'd0);
    check("abort.busy",        32'(bus1.busy),        32'd0);
    check("abort.done",        32'(bus1.done),        32'd0);
    check("abort.match_count", 32'(bus1.match_count), 32'd0);
    check("abort.cycle_count", 32'(bus1.cycle_count), 32'd0);
    reset_n = 1'b1;
    bus1.test_value = 16'h0;
    tick();
    run_vec(vecs[0]);

    // Smoke run with count 0; a table write during RUN must be dropped.
    bus1.test_value = 16'h0;
    bus1.exp_count  = 5'd0;
    bus1.start      = 1'b1;
    tick();
    bus1.start      = 1'b0;
    tick();
    write_exp(4'd0, 16'hFFFF);
    bus1.test_value = 16'h5;
    fin = 0;
    for (int k = 0; k < 100 && !fin; k++) begin
      if (k == 10) bus1.test_value = 16'hA;
      tick();
      if (bus1.done) fin = 1;
    end
    if (!fin) check("smoke.done_within_bound", 32'd0, 32'd1);
    check("smoke.pass",        32'(bus1.pass),        32'd1);
    check("smoke.timeout",     32'(bus1.timeout),     32'd0);
    check("smoke.match_count", 32'(bus1.match_count), 32'd0);
    check("smoke.cycle_count", 32'(bus1.cycle_count), 32'd45);
    bus1.test_value = 16'h0;
    tick();
    run_vec(vecs[0]);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  // Absolute time limit so the bench can never hang.
  initial begin
    #200000;
    $display("FAIL global_time_limit: got expired expected finish");
    $fatal(1, "time limit");
  end

endmodule : tb_mips_test_sequencer
